// File: rtl/rx_unpack_slave_lite_s00_axi_pkg.sv
// Shared constants for the wifi_pack receive-side AXI4-Lite slave: register map,
// CTRL/STATUS bit positions and output FSM encodings.
package rx_unpack_slave_lite_s00_axi_pkg;

    localparam int N_WORDS    = 56;
    localparam int TOTAL_BITS = N_WORDS * 32;
    localparam int IDX_W      = 6;

    localparam logic [IDX_W-1:0] IDX_CTRL  = 6'd56;
    localparam logic [IDX_W-1:0] IDX_COUNT = 6'd57;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_ERRCLR = 2;

    localparam int STAT_VALID = 1;
    localparam int STAT_ERR   = 2;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    function automatic logic [31:0] make_status(input logic err, input logic valid);
        logic [31:0] s;
        s = '0;
        s[STAT_ERR]   = err;
        s[STAT_VALID] = valid;
        return s;
    endfunction

endpackage

// File: rtl/rx_unpack_slave_lite_s00_axi_hs.sv
// AXI4-Lite handshake engine: turns AW/W/B and AR/R traffic into single-cycle
// register write strobes and registered read responses.
module axil_slave_hs
    import rx_unpack_slave_lite_s00_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            wr_en,
    output logic [IDX_W-1:0]                wr_idx,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb,
    output logic                            rd_en,
    output logic [IDX_W-1:0]                rd_idx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data
);

    // Handshake rule on every channel: a beat transfers on the rising edge where
    // VALID and READY are both high; VALID, once raised, holds until that edge.

    logic                            aw_seen_q, w_seen_q;
    logic [IDX_W-1:0]                aw_idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_q;

    logic aw_hs, w_hs, aw_seen_n, w_seen_n, wr_fire, bvalid_n;
    logic unused_addr;

    assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs      = S_AXI_WVALID && S_AXI_WREADY;
        aw_seen_n = aw_seen_q || aw_hs;
        w_seen_n  = w_seen_q || w_hs;
        wr_fire   = aw_seen_n && w_seen_n;
        bvalid_n  = wr_fire || (S_AXI_BVALID && !S_AXI_BREADY);
    end

    // Address/data come from the live bus when that half arrives in the firing cycle.
    assign wr_en   = wr_fire;
    assign wr_idx  = aw_seen_q ? aw_idx_q : S_AXI_AWADDR[IDX_W+1:2];
    assign wr_data = w_seen_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_seen_q ? w_strb_q : S_AXI_WSTRB;

    assign rd_en  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign rd_idx = S_AXI_ARADDR[IDX_W+1:2];

    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_seen_q     <= 1'b0;
            w_seen_q      <= 1'b0;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
        end else begin
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[IDX_W+1:2];
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            aw_seen_q     <= aw_seen_n && !wr_fire;
            w_seen_q      <= w_seen_n && !wr_fire;
            S_AXI_BVALID  <= bvalid_n;
            S_AXI_AWREADY <= !bvalid_n && !(aw_seen_n && !wr_fire);
            S_AXI_WREADY  <= !bvalid_n && !(w_seen_n && !wr_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
            if (rd_en) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_data;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rx_unpack_slave_lite_s00_axi.sv
// PS->PL receive slave: PS stages a 56-word packet, commits it with GO, and the
// committed copy is offered to the PL decrypt path while staging can be refilled.
module rx_unpack_slave_lite_s00_axi
    import rx_unpack_slave_lite_s00_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [TOTAL_BITS-1:0]           data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            irq_o,
    output logic [0:0]                      fsm_state
);

    logic                            wr_en, rd_en;
    logic [IDX_W-1:0]                wr_idx, rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data, rd_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;

    // Word 0 is the leftmost element, so it lands in the packet MSBs.
    logic [0:N_WORDS-1][31:0] stage_q;
    logic [TOTAL_BITS-1:0]    data_q;
    logic [0:0]               state_q;
    logic                     err_q, irq_q;
    logic [31:0]              count_q;

    logic wr_stage, wr_ctrl, go, clr, errclr, accept;
    logic unused_sigs;

    assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, rd_en};

    axil_slave_hs #(
        .C_S_AXI_DATA_WIDTH(C_S_AXI_DATA_WIDTH),
        .C_S_AXI_ADDR_WIDTH(C_S_AXI_ADDR_WIDTH)
    ) u_hs (
        .clk          (S_AXI_ACLK),
        .rst          (S_AXI_ARESET),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .rd_en        (rd_en),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data)
    );

    always_comb begin
        wr_stage = wr_en && (wr_idx < IDX_CTRL);
        wr_ctrl  = wr_en && (wr_idx == IDX_CTRL);
        go       = wr_ctrl && wr_strb[0] && wr_data[CTRL_GO];
        clr      = wr_ctrl && wr_strb[0] && wr_data[CTRL_CLR];
        errclr   = wr_ctrl && wr_strb[0] && wr_data[CTRL_ERRCLR];
        accept   = (state_q == ST_FULL) && ready_i;
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx < IDX_CTRL)        rd_data = stage_q[rd_idx];
        else if (rd_idx == IDX_CTRL)  rd_data = make_status(err_q, state_q == ST_FULL);
        else if (rd_idx == IDX_COUNT) rd_data = count_q;
    end

    // Commit samples the pre-write staging, so GO|CLR commits then zeroes.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            stage_q <= '0;
        end else if (clr) begin
            stage_q <= '0;
        end else if (wr_stage) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) stage_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
            count_q <= '0;
        end else begin
            irq_q <= accept;
            if (accept) count_q <= count_q + 32'd1;
            if (errclr) err_q <= 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    if (go) begin
                        data_q  <= stage_q;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        if (go) data_q <= stage_q;
                        else    state_q <= ST_EMPTY;
                    end else if (go) begin
                        // Pending packet wins; overrun is flagged, not overwritten.
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign data_o    = data_q;
    assign valid_o   = (state_q == ST_FULL);
    assign irq_o     = irq_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_rx_unpack_slave_lite_s00_axi.sv
// Bench for the receive-side packet slave: register map, commit/accept flow,
// overrun error, channel ordering and asynchronous reset.
module tb_rx_unpack_slave_lite_s00_axi;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [1791:0] data_o;
    logic          valid_o, ready_i, irq_o;
    logic [0:0]    fsm_state;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   m_stage[56];
    logic [1791:0] m_data;
    logic          irq_at_fire;

    always #5 clk = ~clk;

    rx_unpack_slave_lite_s00_axi dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .irq_o        (irq_o),
        .fsm_state    (fsm_state)
    );

    function automatic logic [1791:0] pack_model();
        logic [1791:0] v;
        v = '0;
        for (int j = 0; j < 56; j++) v[1791-32*j -: 32] = m_stage[j];
        return v;
    endfunction

    // Driver: AW and W presented together; optionally raises ready_i on the firing edge.
    task automatic axi_write(input logic [5:0] idx, input logic [31:0] data,
                             input logic [3:0] strb, input logic coincide);
        int   cyc;
        logic aw_go, w_go;
        @(negedge clk);
        awaddr = {idx, 2'b00}; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
        cyc = 0;
        while ((awvalid || wvalid) && cyc < 50) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            if (coincide && (aw_go || !awvalid) && (w_go || !wvalid)) ready_i = 1'b1;
            @(negedge clk);
            if (coincide && ready_i) begin
                irq_at_fire = irq_o;
                ready_i = 1'b0;
            end
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid = 1'b0;
            cyc++;
        end
        while (!bvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!bvalid || bresp !== 2'b00) begin
            errors++;
            $display("FAIL write_resp idx=%0d got bvalid=%0b bresp=%0d expected bvalid=1 bresp=0",
                     idx, bvalid, bresp);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Monitor: pops the scoreboard entry queued for this read when RVALID shows up.
    task automatic axi_read(input logic [5:0] idx, input logic [31:0] expv, input string name);
        int          cyc;
        logic        ar_go;
        logic [31:0] e;
        exp_q.push_back(expv);
        @(negedge clk);
        araddr = {idx, 2'b00}; arvalid = 1'b1; rready = 1'b1;
        cyc = 0;
        while (arvalid && cyc < 50) begin
            ar_go = arready;
            @(negedge clk);
            if (ar_go) arvalid = 1'b0;
            cyc++;
        end
        while (!rvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        e = exp_q.pop_front();
        checks++;
        if (!rvalid) begin
            errors++;
            $display("FAIL %s idx=%0d got no RVALID expected rdata=%h", name, idx, e);
            arvalid = 1'b0;
        end else if (rdata !== e || rresp !== 2'b00) begin
            errors++;
            $display("FAIL %s idx=%0d got rdata=%h rresp=%0d expected rdata=%h rresp=0",
                     name, idx, rdata, rresp, e);
        end
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic pulse_ready(input logic [31:0] exp_count);
        @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        checks++;
        if (irq_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL accept got irq=%0b valid=%0b expected irq=1 valid=0", irq_o, valid_o);
        end
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_width got irq=%0b expected 0", irq_o);
        end
        axi_read(6'd57, exp_count, "count_after_accept");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0; ready_i = 1'b0;
        irq_at_fire = 1'b0;
        for (int j = 0; j < 56; j++) m_stage[j] = '0;
        m_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_axi got aw/w/b/ar/r=%b expected 00000",
                     {awready, wready, bvalid, arready, rvalid});
        end
        checks++;
        if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp got bresp=%0d rresp=%0d rdata=%h expected 0 0 0",
                     bresp, rresp, rdata);
        end
        checks++;
        if (valid_o !== 1'b0 || irq_o !== 1'b0 || data_o !== '0) begin
            errors++;
            $display("FAIL reset_out got valid=%0b irq=%0b data_nonzero=%0b expected 0 0 0",
                     valid_o, irq_o, |data_o);
        end
        rst = 1'b0;
        axi_read(6'd57, 32'h0, "reset_count");
        axi_read(6'd56, 32'h0, "reset_status");
        axi_read(6'd0,  32'h0, "reset_stage0");
    endtask

    task automatic test_fill_commit();
        for (int j = 0; j < 56; j++) begin
            axi_write(6'(j), 32'h1000_0000 + 32'(j), 4'hF, 1'b0);
            m_stage[j] = 32'h1000_0000 + 32'(j);
        end
        axi_read(6'd0,  32'h1000_0000, "fill_w0");
        axi_read(6'd27, 32'h1000_001B, "fill_w27");
        axi_read(6'd55, 32'h1000_0037, "fill_w55");
        axi_write(6'd56, 32'h1, 4'hF, 1'b0);
        m_data = pack_model();
        checks++;
        if (valid_o !== 1'b1 || data_o !== m_data) begin
            errors++;
            $display("FAIL commit got valid=%0b data_match=%0b expected valid=1 match=1",
                     valid_o, data_o === m_data);
        end
        checks++;
        if (data_o[1791:1760] !== 32'h1000_0000 || data_o[31:0] !== 32'h1000_0037) begin
            errors++;
            $display("FAIL commit_ends got first=%h last=%h expected 10000000 10000037",
                     data_o[1791:1760], data_o[31:0]);
        end
        pulse_ready(32'd1);
        axi_read(6'd56, 32'h0, "status_after_accept");
    endtask

    task automatic test_overrun();
        axi_write(6'd56, 32'h1, 4'hF, 1'b0);
        m_data = pack_model();
        axi_write(6'd0, 32'hAAAA_0000, 4'hF, 1'b0);
        m_stage[0] = 32'hAAAA_0000;
        axi_write(6'd56, 32'h1, 4'hF, 1'b0);
        axi_read(6'd56, 32'h6, "status_overrun");
        checks++;
        if (valid_o !== 1'b1 || data_o !== m_data) begin
            errors++;
            $display("FAIL overrun_hold got valid=%0b first=%h expected valid=1 first=%h",
                     valid_o, data_o[1791:1760], m_data[1791:1760]);
        end
        axi_write(6'd56, 32'h4, 4'hF, 1'b0);
        axi_read(6'd56, 32'h2, "status_errclr");
    endtask

    task automatic test_back_to_back();
        irq_at_fire = 1'b0;
        axi_write(6'd56, 32'h1, 4'hF, 1'b1);
        m_data = pack_model();
        checks++;
        if (irq_at_fire !== 1'b1 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_flags got irq=%0b valid=%0b expected 1 1", irq_at_fire, valid_o);
        end
        checks++;
        if (data_o !== m_data || data_o[1791:1760] !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL b2b_data got first=%h expected aaaa0000", data_o[1791:1760]);
        end
        axi_read(6'd57, 32'd2, "b2b_count");
        axi_read(6'd56, 32'h2, "b2b_status");
        pulse_ready(32'd3);
    endtask

    task automatic test_strobe_clear();
        axi_write(6'd3, 32'hFFFF_FFFF, 4'hF, 1'b0);
        axi_write(6'd3, 32'h1234_5678, 4'b0101, 1'b0);
        m_stage[3] = 32'hFF34_FF78;
        axi_read(6'd3, 32'hFF34_FF78, "wstrb_merge");
        axi_write(6'd60, 32'hDEAD_BEEF, 4'hF, 1'b0);
        axi_write(6'd57, 32'h0000_0055, 4'hF, 1'b0);
        axi_read(6'd60, 32'h0, "unmapped_read");
        axi_read(6'd57, 32'd3, "count_readonly");
        axi_write(6'd56, 32'h2, 4'hF, 1'b0);
        for (int j = 0; j < 56; j++) m_stage[j] = '0;
        axi_read(6'd3, 32'h0, "clr_w3");
        axi_read(6'd0, 32'h0, "clr_w0");
        axi_write(6'd5, 32'h5555_0005, 4'hF, 1'b0);
        m_stage[5] = 32'h5555_0005;
        axi_write(6'd56, 32'h3, 4'hF, 1'b0);
        m_data = pack_model();
        m_stage[5] = '0;
        checks++;
        if (valid_o !== 1'b1 || data_o !== m_data) begin
            errors++;
            $display("FAIL go_clr_commit got valid=%0b w5=%h expected valid=1 w5=55550005",
                     valid_o, data_o[1791-160 -: 32]);
        end
        axi_read(6'd5, 32'h0, "go_clr_stage");
        pulse_ready(32'd4);
    endtask

    task automatic test_ordering();
        int   cyc;
        int   b_high;
        logic go_flag;
        // AW leads W by five cycles, response held off for three cycles.
        @(negedge clk);
        awaddr = {6'd10, 2'b00}; awvalid = 1'b1; bready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            go_flag = awvalid && awready;
            @(negedge clk);
            if (go_flag) awvalid = 1'b0;
        end
        checks++;
        if (awvalid !== 1'b0 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL aw_first got aw_pending=%0b bvalid=%0b expected 0 0", awvalid, bvalid);
            awvalid = 1'b0;
        end
        wdata = 32'hCAFE_0010; wstrb = 4'hF; wvalid = 1'b1;
        cyc = 0;
        while (wvalid && cyc < 20) begin
            go_flag = wready;
            @(negedge clk);
            if (go_flag) wvalid = 1'b0;
            cyc++;
        end
        b_high = 0;
        for (int i = 0; i < 3; i++) begin
            if (bvalid) b_high++;
            @(negedge clk);
        end
        checks++;
        if (b_high != 3 || wvalid !== 1'b0) begin
            errors++;
            $display("FAIL bvalid_hold got cycles=%0d expected 3", b_high);
            wvalid = 1'b0;
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        b_high = 0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid) b_high++;
            @(negedge clk);
        end
        checks++;
        if (b_high != 0) begin
            errors++;
            $display("FAIL single_bresp got extra_cycles=%0d expected 0", b_high);
        end
        m_stage[10] = 32'hCAFE_0010;
        axi_read(6'd10, 32'hCAFE_0010, "aw_first_data");
        // W leads AW with a GO; a duplicate GO would set ERR.
        @(negedge clk);
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        cyc = 0;
        while (wvalid && cyc < 20) begin
            go_flag = wready;
            @(negedge clk);
            if (go_flag) wvalid = 1'b0;
            cyc++;
        end
        repeat (3) @(negedge clk);
        awaddr = {6'd56, 2'b00}; awvalid = 1'b1;
        cyc = 0;
        while (awvalid && cyc < 20) begin
            go_flag = awready;
            @(negedge clk);
            if (go_flag) awvalid = 1'b0;
            cyc++;
        end
        b_high = 0;
        for (int i = 0; i < 3; i++) begin
            if (bvalid) b_high++;
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        m_data = pack_model();
        checks++;
        if (b_high != 3 || bvalid !== 1'b0 || valid_o !== 1'b1 || data_o !== m_data) begin
            errors++;
            $display("FAIL w_first got bhigh=%0d bvalid=%0b valid=%0b expected 3 0 1",
                     b_high, bvalid, valid_o);
            wvalid = 1'b0; awvalid = 1'b0;
        end
        axi_read(6'd56, 32'h2, "w_first_once");
    endtask

    task automatic test_reset_mid();
        int   cyc;
        logic go_flag;
        @(negedge clk);
        araddr = {6'd57, 2'b00}; arvalid = 1'b1; rready = 1'b0;
        cyc = 0;
        while (arvalid && cyc < 20) begin
            go_flag = arready;
            @(negedge clk);
            if (go_flag) arvalid = 1'b0;
            cyc++;
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got rvalid=%0b valid=%0b expected 1 1", rvalid, valid_o);
            arvalid = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || rvalid !== 1'b0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got valid=%0b rvalid=%0b irq=%0b expected 0 0 0",
                     valid_o, rvalid, irq_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 56; j++) m_stage[j] = '0;
        axi_read(6'd57, 32'h0, "count_after_reset");
        axi_read(6'd56, 32'h0, "status_after_reset");
        axi_read(6'd10, 32'h0, "stage_after_reset");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_commit();
        test_overrun();
        test_back_to_back();
        test_strobe_clear();
        test_ordering();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
